dmem_sram_responder: RTL and testbench
======================================

// Module: dmem_sram_responder
// PURPOSE
//   Data-memory responder on the CPU's sram-like data port: accepts byte-laned read/write
//   requests (wstrb/wdata already lane-positioned by the CPU-side store logic), commits writes,
//   returns full 32-bit read words in order after a fixed programmable latency.
//   Used as the data RAM model behind the memory stage for integration and stall-path testing.
// PARAMETERS
//   ADDR_WIDTH       10  word-address bits; depth = 2**ADDR_WIDTH words
//   LATENCY          1   accept-to-data_ok delay in cycles, legal 1..7
//   MAX_OUTSTANDING  2   accepted-but-unanswered request limit, legal 1..4
// PORTS
//   clk      in   1   clock, rising edge
//   resetn   in   1   asynchronous active-low reset
//   req      in   1   request valid
//   wr       in   1   1 = write, 0 = read
//   size     in   2   0 byte, 1 half, 2 word, 3 illegal
//   addr     in   32  byte address; bits [ADDR_WIDTH+1:2] index the array, upper bits ignored
//   wstrb    in   4   write byte enables, bit i -> wdata[8i+7:8i]
//   wdata    in   32  lane-positioned write data
//   addr_ok  out  1   request accepted this edge when req & addr_ok
//   data_ok  out  1   one-cycle response pulse, in acceptance order
//   rdata    out  32  read word, valid only with data_ok on a read response, else 0
//   err      out  1   alignment/strobe error flag, valid only with data_ok
// BEHAVIOUR
// - Reset (resetn low, async): addr_ok=0, data_ok=0, rdata=0, err=0, response queue and
//   outstanding count cleared. Array contents not reset (sim-init to 0).
// - addr_ok = resetn & (count < MAX_OUTSTANDING); combinational from registered count, no
//   bypass from a same-cycle data_ok.
// - Legality: byte any addr; half needs addr[0]=0; word needs addr[1:0]=0; size 3 illegal.
//   Writes also need exact wstrb: byte 1<<addr[1:0], half 0011/1100 by addr[1], word 1111.
// - At accept edge: legal write updates only strobed bytes; legal read samples the whole word
//   (post-update semantics not needed, one request per edge). Illegal: no array change.
// - Each accepted request pushes {is_read, err, word} into an in-order queue with age counter.
// - Latency: accepted at edge k -> data_ok high in the cycle after edge k+LATENCY-1 (LATENCY=1:
//   pulse in the very next cycle). data_ok, rdata, err are registered.
// - Pipelining: with req held, one accept per edge while count < MAX; sustained throughput
//   min(1, MAX_OUTSTANDING/LATENCY) responses per cycle. Order preserved.
// - count: +1 on accept, -1 on data_ok, unchanged when both on the same edge; never exceeds
//   MAX_OUTSTANDING, never underflows.
// - Responses to writes: data_ok pulse, rdata=0, err per legality. Illegal reads: rdata=0,err=1.
// - Index wrap: addresses differing only above bit ADDR_WIDTH+1 alias to the same word.
// - Reset mid-operation: pending responses discarded (no data_ok after release); writes
//   already committed remain; addr_ok=1 in first cycle after release.
// TESTING
// 1. LATENCY=1: word write 0x10 = 0xDEADBEEF, wstrb 1111; word read 0x10 -> data_ok next cycle,
//    rdata 0xDEADBEEF, err 0.
// 2. Byte write 0x13, wdata 0xAAAAAAAA, wstrb 1000; word read 0x10 -> rdata 0xAAADBEEF.
// 3. Half write 0x12, wdata 0x55665566, wstrb 1100; word read 0x10 -> rdata 0x5566BEEF.
// 4. Word write 0x22 (misaligned) and half write 0x10 with wstrb 1100 -> both err=1; word read
//    0x20 -> 0x00000000, read 0x10 still 0x5566BEEF.
// 5. LATENCY=3, MAX_OUTSTANDING=2, req held with 6 reads -> addr_ok low after 2 accepts, each
//    data_ok exactly 3 cycles after its accept, rdata in request order, count never > 2.
// 6. Two reads outstanding, pulse resetn low 1 cycle -> no data_ok after release, addr_ok=1,
//    read of location written before reset returns the committed value.

Source files
------------

// File: rtl/dmem_sram_responder_if.sv
// Data-port bus between the CPU memory stage and the data RAM responder.
// The master drives requests. The slave answers with addr_ok and with data_ok/rdata/err.
interface dmem_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/dmem_sram_responder.sv
// Data RAM responder for the sram-like data port.
// It accepts byte-laned reads and writes and commits writes at the accept edge.
// Responses come back in order after LATENCY cycles, with at most MAX_OUTSTANDING in flight.
module dmem_sram_responder #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  dmem_sram_responder_if.slave  bus
);

  localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
  localparam int unsigned QDepth = 4;
  // An entry pops at the edge where it has already been held for LATENCY-2 edges.
  localparam int unsigned PopAge = (LATENCY > 1) ? LATENCY - 2 : 0;

  logic [31:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_addr_hi;
  logic                  legal;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [31:0]           rd_word;

  logic [2:0]        count_q;
  logic              data_ok_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [QDepth-1:0] q_valid;
  logic [QDepth-1:0] q_err;
  logic [31:0]       q_rdata [QDepth];
  logic [2:0]        q_age [QDepth];
  logic [1:0]        wr_ptr_q;
  logic [1:0]        rd_ptr_q;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign idx            = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

  assign bus.addr_ok = resetn & (count_q < 3'(MAX_OUTSTANDING));
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;

  assign accept = bus.req & bus.addr_ok;
  // With LATENCY 1 the response register loads straight from the request, bypassing the queue.
  assign push   = accept && (LATENCY > 1);
  assign pop    = q_valid[rd_ptr_q] && (q_age[rd_ptr_q] == 3'(PopAge));

  // Alignment and exact-strobe legality of the current request.
  always_comb begin
    legal = 1'b0;
    case (bus.size)
      2'd0: legal = !bus.wr || (bus.wstrb == (4'b0001 << bus.addr[1:0]));
      2'd1: legal = !bus.addr[0] &&
                    (!bus.wr || (bus.wstrb == (bus.addr[1] ? 4'b1100 : 4'b0011)));
      2'd2: legal = (bus.addr[1:0] == 2'b00) && (!bus.wr || (bus.wstrb == 4'b1111));
      default: legal = 1'b0;
    endcase
  end

  // Read data is sampled at the accept edge; writes and illegal requests return zero.
  always_comb begin
    rd_word = 32'h0;
    if (!bus.wr && legal) begin
      rd_word = mem[idx];
    end
  end

  // Commit the strobed bytes of a legal write. The array has no reset, so committed data
  // survives a reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr && legal) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  // In-order response queue with per-entry age, registered response outputs and the
  // outstanding count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= 3'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      q_valid   <= '0;
      q_err     <= '0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      for (int i = 0; i < QDepth; i++) begin
        q_rdata[i] <= 32'h0;
        q_age[i]   <= 3'd0;
      end
    end else begin
      for (int i = 0; i < QDepth; i++) begin
        if (q_valid[i] && (q_age[i] != 3'd7)) begin
          q_age[i] <= q_age[i] + 3'd1;
        end
      end

      if (pop) begin
        q_valid[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_next(rd_ptr_q);
      end

      // The push slot is never valid, because count bounds the occupancy.
      if (push) begin
        q_valid[wr_ptr_q] <= 1'b1;
        q_err[wr_ptr_q]   <= !legal;
        q_rdata[wr_ptr_q] <= rd_word;
        q_age[wr_ptr_q]   <= 3'd0;
        wr_ptr_q          <= ptr_next(wr_ptr_q);
      end

      if (accept && (LATENCY == 1)) begin
        data_ok_q <= 1'b1;
        rdata_q   <= rd_word;
        err_q     <= !legal;
      end else if (pop) begin
        data_ok_q <= 1'b1;
        rdata_q   <= q_rdata[rd_ptr_q];
        err_q     <= q_err[rd_ptr_q];
      end else begin
        data_ok_q <= 1'b0;
        rdata_q   <= 32'h0;
        err_q     <= 1'b0;
      end

      unique case ({accept, data_ok_q})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Directed bench for dmem_sram_responder.
// It uses two instances: LATENCY 1 (dut_a) and LATENCY 3 with two outstanding (dut_b).
// Expected responses are queued when a request is accepted and popped on data_ok.
module tb_dmem_sram_responder;

  localparam int LatA = 1;
  localparam int LatB = 3;
  localparam int MaxA = 2;
  localparam int MaxB = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn_a;
  logic rstn_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mcnt_a = 0;
  int   mcnt_b = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea;
  exp_t eb;

  dmem_sram_responder_if ifa ();
  dmem_sram_responder_if ifb ();

  dmem_sram_responder #(
    .ADDR_WIDTH      (10),
    .LATENCY         (LatA),
    .MAX_OUTSTANDING (MaxA)
  ) dut_a (
    .clk    (clk),
    .resetn (rstn_a),
    .bus    (ifa)
  );

  dmem_sram_responder #(
    .ADDR_WIDTH      (10),
    .LATENCY         (LatB),
    .MAX_OUTSTANDING (MaxB)
  ) dut_b (
    .clk    (clk),
    .resetn (rstn_b),
    .bus    (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic r, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
    if (id == 0) begin
      ifa.req = r; ifa.wr = w; ifa.size = sz; ifa.addr = a; ifa.wstrb = st; ifa.wdata = wd;
    end else begin
      ifb.req = r; ifb.wr = w; ifb.size = sz; ifb.addr = a; ifb.wstrb = st; ifb.wdata = wd;
    end
  endtask

  task automatic idle(input int id);
    drive(id, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the request until it is accepted, queueing its expected response at that point.
  task automatic issue(input int id, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] st, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    bit   done;
    drive(id, 1'b1, w, sz, a, st, wd);
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if ((id == 0) ? ifa.addr_ok : ifb.addr_ok) begin
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + ((id == 0) ? LatA : LatB);
        if (id == 0) sb_a.push_back(e);
        else         sb_b.push_back(e);
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          chk("accept_timeout", n, 0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while (((id == 0) ? sb_a.size() : sb_b.size()) > 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", (id == 0) ? sb_a.size() : sb_b.size(), 0);
  endtask

  // Response and addr_ok monitor for dut_a. The outstanding model applies the +1/-1 rule.
  always @(negedge clk) begin
    if (!rstn_a) begin
      chk("a_rst_addr_ok", ifa.addr_ok, 0);
      chk("a_rst_data_ok", ifa.data_ok, 0);
      chk("a_rst_rdata", ifa.rdata, 0);
      mcnt_a = 0;
    end else begin
      chk("a_addr_ok", ifa.addr_ok, (mcnt_a < MaxA));
      if (ifa.data_ok) begin
        if (sb_a.size() == 0) begin
          chk("a_spurious_data_ok", ifa.data_ok, 0);
        end else begin
          ea = sb_a.pop_front();
          chk("a_rdata", ifa.rdata, ea.rdata);
          chk("a_err", ifa.err, ea.err);
          chk("a_latency", cyc, ea.cyc);
        end
      end else begin
        chk("a_idle_rdata", ifa.rdata, 0);
        chk("a_idle_err", ifa.err, 0);
      end
      mcnt_a = mcnt_a + int'(ifa.req && ifa.addr_ok) - int'(ifa.data_ok);
    end
  end

  // Response and addr_ok monitor for dut_b.
  always @(negedge clk) begin
    if (!rstn_b) begin
      chk("b_rst_addr_ok", ifb.addr_ok, 0);
      chk("b_rst_data_ok", ifb.data_ok, 0);
      chk("b_rst_rdata", ifb.rdata, 0);
      mcnt_b = 0;
    end else begin
      chk("b_addr_ok", ifb.addr_ok, (mcnt_b < MaxB));
      if (ifb.data_ok) begin
        if (sb_b.size() == 0) begin
          chk("b_spurious_data_ok", ifb.data_ok, 0);
        end else begin
          eb = sb_b.pop_front();
          chk("b_rdata", ifb.rdata, eb.rdata);
          chk("b_err", ifb.err, eb.err);
          chk("b_latency", cyc, eb.cyc);
        end
      end else begin
        chk("b_idle_rdata", ifb.rdata, 0);
        chk("b_idle_err", ifb.err, 0);
      end
      mcnt_b = mcnt_b + int'(ifb.req && ifb.addr_ok) - int'(ifb.data_ok);
    end
  end

  initial begin
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    idle(0);
    idle(1);
    cycles(3);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    cycles(1);

    // Latency 1: word write then read back.
    issue(0, 1'b1, 2'd2, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(0, 1'b0, 2'd2, 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
    // Byte write to lane 3.
    issue(0, 1'b1, 2'd0, 32'h13, 4'b1000, 32'hAAAAAAAA, 32'h0, 1'b0);
    issue(0, 1'b0, 2'd2, 32'h10, 4'b0000, 32'h0, 32'hAAADBEEF, 1'b0);
    // Upper half write.
    issue(0, 1'b1, 2'd1, 32'h12, 4'b1100, 32'h55665566, 32'h0, 1'b0);
    issue(0, 1'b0, 2'd2, 32'h10, 4'b0000, 32'h0, 32'h5566BEEF, 1'b0);
    // Misaligned word write and wrong-strobe half write are rejected.
    issue(0, 1'b1, 2'd2, 32'h22, 4'b1111, 32'h11111111, 32'h0, 1'b1);
    issue(0, 1'b1, 2'd1, 32'h10, 4'b1100, 32'h22222222, 32'h0, 1'b1);
    issue(0, 1'b0, 2'd2, 32'h20, 4'b0000, 32'h0, 32'h00000000, 1'b0);
    issue(0, 1'b0, 2'd2, 32'h10, 4'b0000, 32'h0, 32'h5566BEEF, 1'b0);
    // Illegal reads, a legal byte read returning the full word, and aliasing above the index.
    issue(0, 1'b0, 2'd3, 32'h10, 4'b0000, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 2'd1, 32'h11, 4'b0000, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 2'd0, 32'h11, 4'b0000, 32'h0, 32'h5566BEEF, 1'b0);
    issue(0, 1'b0, 2'd2, 32'h4010, 4'b0000, 32'h0, 32'h5566BEEF, 1'b0);
    idle(0);
    drain(0);

    // Latency 3 with two outstanding: prefill, then six reads with req held.
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b1, 2'd2, 32'h100 + 32'(4 * i), 4'b1111, 32'hA5000000 | 32'(i), 32'h0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b0, 2'd2, 32'h100 + 32'(4 * (i % 4)), 4'b0000, 32'h0,
            32'hA5000000 | 32'(i % 4), 1'b0);
    end
    idle(1);
    drain(1);

    // Reset with two reads in flight: they are dropped, and committed data survives.
    issue(1, 1'b1, 2'd2, 32'h40, 4'b1111, 32'h12345678, 32'h0, 1'b0);
    idle(1);
    drain(1);
    issue(1, 1'b0, 2'd2, 32'h40, 4'b0000, 32'h0, 32'h12345678, 1'b0);
    issue(1, 1'b0, 2'd2, 32'h44, 4'b0000, 32'h0, 32'h0, 1'b0);
    idle(1);
    rstn_b = 1'b0;
    sb_b.delete();
    cycles(1);
    rstn_b = 1'b1;
    @(negedge clk);
    chk("b_addr_ok_after_reset", ifb.addr_ok, 1);
    cycles(6);
    issue(1, 1'b0, 2'd2, 32'h40, 4'b0000, 32'h0, 32'h12345678, 1'b0);
    idle(1);
    drain(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
